instr_imm_encoder: RTL and testbench

- Pipelined immediate encoder: the inverse of the decode-stage immediate sign extender.
- Takes a 32-bit instruction template, a 32-bit signed immediate and an immediate format.
- Produces the instruction with the immediate scattered into the RISC-V I/S/B/J bit positions.
- Flags immediates that are unrepresentable or misaligned.
- Used by the boot/test program loader and the self-check generator to patch branch/jump/load offsets before writing instruction memory.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/skid_buffer.sv | 44 ++++
 rtl/instr_imm_encoder.sv | 55 +++++
 tb/tb_instr_imm_encoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: immediate format encoding shared with the decode-stage sign extender,
// plus the representable range of each immediate format.
package riscv_pkg;
   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_src_t;
   localparam int IMM_IS_MIN = -2048;
   localparam int IMM_IS_MAX = 2047;
   localparam int IMM_B_MIN = -4096;
   localparam int IMM_B_MAX = 4094;
   localparam int IMM_J_MIN = -1048576;
   localparam int IMM_J_MAX = 1048574;
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: output register plus one skid entry; in_ready depends only on
// registered state, so upstream never sees a combinational path from out_ready.
module skid_buffer #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   state_t state, state_nx;
   logic [W-1:0] skid;
   logic push, pop;
   assign in_ready = state != FULL;
   assign out_valid = state != EMPTY;
   assign push = in_valid && in_ready;
   assign pop = out_valid && out_ready;
   always_comb begin
      state_nx = state;
      case (state)
         EMPTY: state_nx = push ? ONE : EMPTY;
         ONE: state_nx = push && !pop ? FULL : !push && pop ? EMPTY : ONE;
         FULL: state_nx = pop ? ONE : FULL;
         default: state_nx = EMPTY;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
         out_data <= '0;
         skid <= '0;
      end else begin
         state <= state_nx;
         if (state == FULL && pop) out_data <= skid;
         else if (push && (state == EMPTY || pop)) out_data <= in_data;
         if (state == ONE && push && !pop) skid <= in_data;
      end
   end
endmodule

// File: rtl/instr_imm_encoder.sv
// instr_imm_encoder: scatters a signed immediate into RISC-V I/S/B/J fields of a
// template, flags unrepresentable/misaligned immediates, and counts errors.
module instr_imm_encoder
   import riscv_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_templ,
   input  logic [31:0]          in_imm,
   input  logic [1:0]           in_ImmSrc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic                 out_err,
   output logic [CNT_WIDTH-1:0] err_count,
   input  logic                 err_count_clr
);
   imm_src_t src;
   logic signed [31:0] simm;
   logic [31:0] enc;
   logic err, accept;
   logic [32:0] result;
   assign src = imm_src_t'(in_ImmSrc);
   assign simm = in_imm;
   assign enc = src == IMM_I ? {in_imm[11:0], in_templ[19:0]} :
                src == IMM_S ? {in_imm[11:5], in_templ[24:12], in_imm[4:0], in_templ[6:0]} :
                src == IMM_B ? {in_imm[12], in_imm[10:5], in_templ[24:12], in_imm[4:1], in_imm[11], in_templ[6:0]} :
                               {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_templ[11:0]};
   // B and J offsets are in halfwords, so bit 0 must be clear
   assign err = src == IMM_B ? (simm < IMM_B_MIN || simm > IMM_B_MAX || in_imm[0]) :
                src == IMM_J ? (simm < IMM_J_MIN || simm > IMM_J_MAX || in_imm[0]) :
                               (simm < IMM_IS_MIN || simm > IMM_IS_MAX);
   assign accept = in_valid && in_ready;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_count <= '0;
      else if (err_count_clr) err_count <= '0;
      else if (accept && err && err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
   end
   skid_buffer #(.W(33)) u_skid (
      .clk(clk),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data({err, enc}),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(result)
   );
   assign out_err = result[32];
   assign out_instr = result[31:0];
endmodule

// File: tb/tb_instr_imm_encoder.sv
// tb_instr_imm_encoder: directed vectors with hand-computed encodings, error flags,
// counter saturation/clear, backpressure ordering and asynchronous reset.
module tb_instr_imm_encoder;
   import riscv_pkg::*;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [31:0] in_templ = '0;
   logic [31:0] in_imm = '0;
   logic [1:0] in_ImmSrc = '0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [31:0] out_instr;
   logic out_err;
   logic [15:0] err_count;
   logic err_count_clr = 1'b0;
   int checks = 0;
   int failures = 0;

   instr_imm_encoder #(.CNT_WIDTH(16)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_templ(in_templ),
      .in_imm(in_imm),
      .in_ImmSrc(in_ImmSrc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_err(out_err),
      .err_count(err_count),
      .err_count_clr(err_count_clr)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [31:0] t, input logic [31:0] imm, input imm_src_t s);
      in_valid = 1'b1;
      in_templ = t;
      in_imm = imm;
      in_ImmSrc = s;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({out_valid, in_ready, out_err} !== 3'b010) begin
         failures++;
         $display("FAIL reset_flags got=%b want=010", {out_valid, in_ready, out_err});
      end
      checks++;
      if (out_instr !== 32'h0 || err_count !== 16'h0) begin
         failures++;
         $display("FAIL reset_values instr=%h cnt=%h want 0", out_instr, err_count);
      end
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_itype();
      out_ready = 1'b1;
      drive(32'h00000013, 32'hFFFFFFFF, IMM_I);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'hFFF00013 || out_err !== 1'b0 || err_count !== 16'd0) begin
         failures++;
         $display("FAIL itype v=%b instr=%h err=%b cnt=%0d want 1 fff00013 0 0", out_valid, out_instr, out_err, err_count);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL itype_pop out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_btype();
      drive(32'h00000063, 32'hFFFFFFFC, IMM_B);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'hFE000EE3 || out_err !== 1'b0) begin
         failures++;
         $display("FAIL btype v=%b instr=%h err=%b want 1 fe000ee3 0", out_valid, out_instr, out_err);
      end
      step();
   endtask

   task automatic test_jtype();
      drive(32'h0000006F, 32'd2048, IMM_J);
      step();
      checks++;
      if (out_instr !== 32'h0010006F || out_err !== 1'b0) begin
         failures++;
         $display("FAIL jtype_2048 instr=%h err=%b want 0010006f 0", out_instr, out_err);
      end
      drive(32'h0000006F, 32'd3, IMM_J);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_instr !== 32'h0020006F || out_err !== 1'b1 || err_count !== 16'd1) begin
         failures++;
         $display("FAIL jtype_odd instr=%h err=%b cnt=%0d want 0020006f 1 1", out_instr, out_err, err_count);
      end
      step();
   endtask

   task automatic test_stype();
      drive(32'h00002023, 32'hFFFFF800, IMM_S);
      step();
      checks++;
      if (out_instr !== 32'h80002023 || out_err !== 1'b0 || err_count !== 16'd1) begin
         failures++;
         $display("FAIL stype_min instr=%h err=%b cnt=%0d want 80002023 0 1", out_instr, out_err, err_count);
      end
      drive(32'h00002023, 32'd2048, IMM_S);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_instr !== 32'h80002023 || out_err !== 1'b1 || err_count !== 16'd2) begin
         failures++;
         $display("FAIL stype_over instr=%h err=%b cnt=%0d want 80002023 1 2", out_instr, out_err, err_count);
      end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(32'h00000013, 32'd1, IMM_I);
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_instr !== 32'h00100013) begin
         failures++;
         $display("FAIL bp_first v=%b rdy=%b instr=%h want 1 1 00100013", out_valid, in_ready, out_instr);
      end
      drive(32'h00000013, 32'd2, IMM_I);
      step();
      checks++;
      if (in_ready !== 1'b0 || out_instr !== 32'h00100013) begin
         failures++;
         $display("FAIL bp_full rdy=%b instr=%h want 0 00100013", in_ready, out_instr);
      end
      drive(32'h00000013, 32'd3, IMM_I);
      step();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h00100013) begin
         failures++;
         $display("FAIL bp_hold rdy=%b v=%b instr=%h want 0 1 00100013", in_ready, out_valid, out_instr);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_instr !== 32'h00200013 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_pop1 instr=%h rdy=%b v=%b want 00200013 1 1", out_instr, in_ready, out_valid);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_instr !== 32'h00300013 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_pop2 instr=%h v=%b want 00300013 1", out_instr, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || err_count !== 16'd2) begin
         failures++;
         $display("FAIL bp_drain v=%b cnt=%0d want 0 2", out_valid, err_count);
      end
   endtask

   task automatic test_saturate();
      out_ready = 1'b1;
      drive(32'h00000013, 32'd4096, IMM_I);
      for (int i = 0; i < 65540; i++) @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (err_count !== 16'hFFFF || out_err !== 1'b1) begin
         failures++;
         $display("FAIL saturate cnt=%h err=%b want ffff 1", err_count, out_err);
      end
      step();
   endtask

   task automatic test_clear();
      drive(32'h00000063, 32'd5, IMM_B);
      err_count_clr = 1'b1;
      step();
      in_valid = 1'b0;
      err_count_clr = 1'b0;
      checks++;
      if (err_count !== 16'd0 || out_err !== 1'b1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL clear cnt=%0d err=%b v=%b want 0 1 1", err_count, out_err, out_valid);
      end
      step();
   endtask

   task automatic test_reset_full();
      out_ready = 1'b0;
      drive(32'h00000013, 32'd7, IMM_I);
      step();
      drive(32'h00000013, 32'd8, IMM_I);
      step();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL full_before_reset rdy=%b v=%b want 0 1", in_ready, out_valid);
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0) begin
         failures++;
         $display("FAIL async_reset v=%b rdy=%b instr=%h want 0 1 00000000", out_valid, in_ready, out_instr);
      end
      step();
      reset_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_itype();
      test_btype();
      test_jtype();
      test_stype();
      test_backpressure();
      test_saturate();
      test_clear();
      test_reset_full();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
